// File: rtl/gravity_timer.sv
// Gravity timer: counts frame ticks and raises a held drop request when the level/soft-drop period expires.
// Optional feature macro: GRAVITY_MISS_CNT_EN builds the saturating 8-bit missed-expiry counter.
module gravity_timer #(
  parameter int BASE_FRAMES      = 48,
  parameter int FRAMES_PER_LEVEL = 2,
  parameter int MIN_FRAMES       = 2,
  parameter int SOFT_FRAMES      = 3,
  parameter int LEVEL_W          = 5,
  localparam int FRAME_W         = $clog2(BASE_FRAMES + 1)
) (
  input  logic               clk,
  input  logic               iReset,
  input  logic               iTick,
  input  logic               iRun,
  input  logic [LEVEL_W-1:0] iLevel,
  input  logic               iSoftDrop,
  input  logic               iDropAck,
  output logic               oDropReq,
  output logic [FRAME_W-1:0] oFrameCount,
  output logic [7:0]         oMissCount
);

  localparam int PROD_W = LEVEL_W + FRAME_W;
  localparam int CNT_W  = FRAME_W + 1;
  localparam logic [PROD_W-1:0] DROP_LIMIT = PROD_W'(BASE_FRAMES - MIN_FRAMES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    REQ   = 2'd2
  } stateT;

  stateT              state;
  stateT              nextState;
  logic [FRAME_W-1:0] count;
  logic [FRAME_W-1:0] nextCount;
  logic               dropReq;
  logic [PROD_W-1:0]  product;
  logic [FRAME_W-1:0] period;
  logic [CNT_W-1:0]   countInc;
  logic               expiry;

  assign product  = PROD_W'(iLevel) * PROD_W'(FRAMES_PER_LEVEL);
  assign countInc = {1'b0, count} + CNT_W'(1);
  // A period that shrank below the current count still expires on the next tick.
  assign expiry   = iTick && (countInc >= {1'b0, period});

  // Period select: soft drop overrides; a large level product clamps to the floor instead of underflowing.
  always_comb begin
    period = FRAME_W'(MIN_FRAMES);
    if (iSoftDrop) begin
      period = FRAME_W'(SOFT_FRAMES);
    end else if (product >= DROP_LIMIT) begin
      period = FRAME_W'(MIN_FRAMES);
    end else begin
      period = FRAME_W'(PROD_W'(BASE_FRAMES) - product);
    end
  end

  // Next-state and next-count logic; ack never touches the count.
  always_comb begin
    nextState = state;
    nextCount = count;
    if (!iRun) begin
      nextState = IDLE;
      nextCount = '0;
    end else begin
      case (state)
        IDLE: begin
          nextState = COUNT;
          nextCount = '0;
        end
        COUNT: begin
          if (iTick) begin
            nextCount = expiry ? '0 : countInc[FRAME_W-1:0];
          end else begin
            nextCount = count;
          end
          nextState = expiry ? REQ : COUNT;
        end
        REQ: begin
          if (iTick) begin
            nextCount = expiry ? '0 : countInc[FRAME_W-1:0];
          end else begin
            nextCount = count;
          end
          if (expiry) begin
            nextState = REQ;
          end else if (iDropAck) begin
            nextState = COUNT;
          end else begin
            nextState = REQ;
          end
        end
        default: begin
          nextState = IDLE;
          nextCount = '0;
        end
      endcase
    end
  end

  // State, count and registered request.
  always_ff @(posedge clk) begin
    if (iReset) begin
      state   <= IDLE;
      count   <= '0;
      dropReq <= 1'b0;
    end else begin
      state   <= nextState;
      count   <= nextCount;
      dropReq <= (nextState == REQ);
    end
  end

  assign oDropReq    = dropReq;
  assign oFrameCount = count;

`ifdef GRAVITY_MISS_CNT_EN
  logic [7:0] missCount;
  logic       missInc;

  // An expiry while a request is still pending and unacked is a lost drop.
  assign missInc = iRun && (state == REQ) && expiry && !iDropAck;

  // Saturating miss counter; survives iRun=0, cleared only by reset.
  always_ff @(posedge clk) begin
    if (iReset) begin
      missCount <= 8'd0;
    end else if (missInc && (missCount != 8'd255)) begin
      missCount <= missCount + 8'd1;
    end else begin
      missCount <= missCount;
    end
  end

  assign oMissCount = missCount;
`else
  assign oMissCount = 8'd0;
`endif

endmodule

// File: tb/tb_gravity_timer.sv
// Directed self-checking bench for gravity_timer (default parameters, period 48 at level 0).
module tb_gravity_timer;

  logic       clk;
  logic       iReset;
  logic       iTick;
  logic       iRun;
  logic [4:0] iLevel;
  logic       iSoftDrop;
  logic       iDropAck;
  logic       oDropReq;
  logic [5:0] oFrameCount;
  logic [7:0] oMissCount;

  int errors = 0;
  int checks = 0;

  gravity_timer dut (
    .clk         (clk),
    .iReset      (iReset),
    .iTick       (iTick),
    .iRun        (iRun),
    .iLevel      (iLevel),
    .iSoftDrop   (iSoftDrop),
    .iDropAck    (iDropAck),
    .oDropReq    (oDropReq),
    .oFrameCount (oFrameCount),
    .oMissCount  (oMissCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clocks and settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    if (n > 0) #1;
  endtask

  // n ticks, one every gap clocks; with gap=1 the outputs are sampled just after the last tick edge.
  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      iTick = 1'b1;
      step(1);
      iTick = 1'b0;
      step(gap - 1);
    end
  endtask

  task automatic ack();
    iDropAck = 1'b1;
    step(1);
    iDropAck = 1'b0;
  endtask

  task automatic restart();
    iRun = 1'b0;
    step(1);
    iRun = 1'b1;
    step(1);
  endtask

  int expMiss2;
  int expMissSat;

  initial begin
`ifdef GRAVITY_MISS_CNT_EN
    expMiss2   = 2;
    expMissSat = 255;
`else
    expMiss2   = 0;
    expMissSat = 0;
`endif
    iReset = 1'b1; iTick = 1'b0; iRun = 1'b0; iLevel = 5'd0; iSoftDrop = 1'b0; iDropAck = 1'b0;
    #1;
    step(2);
    checkVal("rst_req",   oDropReq,    0);
    checkVal("rst_count", oFrameCount, 0);
    checkVal("rst_miss",  oMissCount,  0);
    iReset = 1'b0;

    // 1: level 0, tick every 4 clocks; entry-cycle tick ignored
    iRun = 1'b1; iTick = 1'b1;
    step(1);
    iTick = 1'b0;
    checkVal("t1_entry_tick", oFrameCount, 0);
    ticks(47, 4);
    checkVal("t1_cnt47",  oFrameCount, 47);
    checkVal("t1_req47",  oDropReq,    0);
    ticks(1, 1);
    checkVal("t1_req48",  oDropReq,    1);
    checkVal("t1_cnt48",  oFrameCount, 0);
    step(3);
    ticks(5, 4);
    checkVal("t1_hold",   oDropReq,    1);
    checkVal("t1_holdcnt", oFrameCount, 5);
    ack();
    checkVal("t1_ack",    oDropReq,    0);
    checkVal("t1_ackcnt", oFrameCount, 5);

    // 2: level 20 -> period 8; level 31 -> clamped to 2
    iLevel = 5'd20;
    restart();
    ticks(7, 2);
    checkVal("t2_l20_cnt7", oFrameCount, 7);
    checkVal("t2_l20_req7", oDropReq,    0);
    ticks(1, 1);
    checkVal("t2_l20_req8", oDropReq,    1);
    ack();
    iLevel = 5'd31;
    ticks(1, 2);
    checkVal("t2_l31_req1", oDropReq,    0);
    checkVal("t2_l31_cnt1", oFrameCount, 1);
    ticks(1, 1);
    checkVal("t2_l31_req2", oDropReq,    1);
    ack();
    ticks(2, 2);
    checkVal("t2_l31_again", oDropReq,   1);

    // 3: soft drop at count 10 expires on the next tick, then every 3 ticks
    iLevel = 5'd0;
    restart();
    ticks(10, 2);
    checkVal("t3_cnt10", oFrameCount, 10);
    iSoftDrop = 1'b1;
    ticks(1, 1);
    checkVal("t3_soft_req", oDropReq,    1);
    checkVal("t3_soft_cnt", oFrameCount, 0);
    ack();
    ticks(2, 2);
    checkVal("t3_soft_req2", oDropReq,   0);
    checkVal("t3_soft_cnt2", oFrameCount, 2);
    ticks(1, 1);
    checkVal("t3_soft_req3", oDropReq,   1);

    // 4: ack + tick in REQ, non-expiring then expiring
    iSoftDrop = 1'b0;
    ticks(5, 2);
    checkVal("t4_req_cnt5", oFrameCount, 5);
    iDropAck = 1'b1; iTick = 1'b1;
    step(1);
    iDropAck = 1'b0; iTick = 1'b0;
    checkVal("t4_acktick_req", oDropReq,    0);
    checkVal("t4_acktick_cnt", oFrameCount, 6);
    ticks(42, 2);
    checkVal("t4_reenter", oDropReq, 1);
    ticks(47, 2);
    checkVal("t4_cnt47", oFrameCount, 47);
    iDropAck = 1'b1; iTick = 1'b1;
    step(1);
    iDropAck = 1'b0; iTick = 1'b0;
    checkVal("t4_fresh_req",  oDropReq,    1);
    checkVal("t4_fresh_cnt",  oFrameCount, 0);
    checkVal("t4_fresh_miss", oMissCount,  0);

    // 5: iRun drop at count 30; reset during REQ
    restart();
    ticks(30, 2);
    checkVal("t5_cnt30", oFrameCount, 30);
    iRun = 1'b0;
    step(1);
    checkVal("t5_idle_cnt", oFrameCount, 0);
    checkVal("t5_idle_req", oDropReq,    0);
    iRun = 1'b1;
    step(1);
    iSoftDrop = 1'b1;
    ticks(3, 2);
    checkVal("t5_req", oDropReq, 1);
    iReset = 1'b1;
    step(1);
    checkVal("t5_rst_req",  oDropReq,    0);
    checkVal("t5_rst_cnt",  oFrameCount, 0);
    checkVal("t5_rst_miss", oMissCount,  0);
    iReset = 1'b0;

    // 6: missed expiries while REQ is held
    iSoftDrop = 1'b0;
    step(1);
    ticks(48, 2);
    checkVal("t6_req", oDropReq, 1);
    ticks(96, 2);
    checkVal("t6_miss2",    oMissCount,  expMiss2);
    checkVal("t6_miss2req", oDropReq,    1);
    checkVal("t6_miss2cnt", oFrameCount, 0);
    iLevel = 5'd31;
    ticks(600, 2);
    checkVal("t6_miss_sat", oMissCount, expMissSat);
    checkVal("t6_sat_req",  oDropReq,   1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
